// File: rtl/date_log_pkg.sv
// Shared defaults, separator codes and entry-width helper for the date match logger.
// DATE_LOG_SEP_EN widens each logged entry by a 2-bit separator code.
package date_log_pkg;

    localparam int POS_W_DEF = 16;
    localparam int DEPTH_DEF = 8;
    localparam int CNT_W_DEF = 8;

    localparam logic [1:0] SEP_NONE  = 2'd0;
    localparam logic [1:0] SEP_DOT   = 2'd1;
    localparam logic [1:0] SEP_DASH  = 2'd2;
    localparam logic [1:0] SEP_SLASH = 2'd3;

    function automatic int entry_w(input int pos_w);
`ifdef DATE_LOG_SEP_EN
        return pos_w + 2;
`else
        return pos_w;
`endif
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic [1:0] sep_code(input logic [7:0] c);
        case (c)
            8'h2e:   return SEP_DOT;
            8'h2d:   return SEP_DASH;
            8'h2f:   return SEP_SLASH;
            default: return SEP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/date_log_fifo.sv
// Synchronous event FIFO; pointers carry an extra wrap bit to separate full from empty.
// A push into a full FIFO only lands when a pop frees a slot in the same cycle.
module date_log_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         dropped
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         empty;
    logic         full;
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dropped = push & full & ~do_pop;

    assign valid = ~empty;
    // Head reads as zero when empty so the output never shows stale storage.
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/date_match_logger.sv
// Logs the stream index of the last char of each completed date-match run into a FIFO.
// DATE_LOG_SEP_EN adds the first separator of the run's stream segment (out_sep).
module date_match_logger
    import date_log_pkg::*;
#(
    parameter int POS_W = POS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_char,
    input  logic             match,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_idx,
    output logic [CNT_W-1:0] ev_count,
`ifdef DATE_LOG_SEP_EN
    output logic [1:0]       out_sep,
`endif
    output logic             overflow
);

    localparam int             EW      = entry_w(POS_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] last_idx;
    logic             prev_match;
    logic             ev;
    logic             dropped;
    logic [EW-1:0]    push_data;
    logic [EW-1:0]    head;

    // match lags the stream by one register, so the char it refers to is pos-1.
    assign ev = prev_match & ~match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos        <= '0;
            prev_match <= 1'b0;
            last_idx   <= '0;
        end else begin
            pos        <= pos + 1'b1;
            prev_match <= match;
            if (match) last_idx <= pos - 1'b1;
        end
    end

`ifdef DATE_LOG_SEP_EN
    logic [1:0] cur_sep;
    logic [1:0] last_sep;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_sep  <= SEP_NONE;
            last_sep <= SEP_NONE;
        end else begin
            if (!is_digit(in_char)) begin
                if (sep_code(in_char) == SEP_NONE) cur_sep <= SEP_NONE;
                else if (cur_sep == SEP_NONE)      cur_sep <= sep_code(in_char);
            end
            if (match) last_sep <= cur_sep;
        end
    end

    assign push_data = {last_sep, last_idx};
    assign out_sep   = head[EW-1 -: 2];
`else
    logic unused_in_char;
    assign unused_in_char = ^in_char;
    assign push_data      = last_idx;
`endif

    assign out_idx = head[POS_W-1:0];

    date_log_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ev),
        .push_data (push_data),
        .pop       (out_ready),
        .head      (head),
        .valid     (out_valid),
        .dropped   (dropped)
    );

    // An event in the same cycle as clr takes precedence: count restarts at one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ev_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (ev) begin
                if (clr)                       ev_count <= CNT_W'(1);
                else if (ev_count != CNT_MAX)  ev_count <= ev_count + 1'b1;
            end else if (clr) begin
                ev_count <= '0;
            end

            if (clr)          overflow <= dropped;
            else if (dropped) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_date_match_logger.sv
// Randomised and directed bench for date_match_logger with a queue-based reference model.
module tb_date_match_logger;

    localparam int POS_W = 4;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [7:0]       in_char = 8'h0;
    logic             match = 1'b0;
    logic             clr = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [POS_W-1:0] out_idx;
    logic [CNT_W-1:0] ev_count;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    int exp_q[$];
    bit hist[$];
    int exp_cnt = 0;
    bit exp_ovf = 1'b0;

    date_match_logger #(
        .POS_W (POS_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_char   (in_char),
        .match     (match),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .ev_count  (ev_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a handshake completes at the next edge, so pop and compare the head now.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_entry: got %0d expected none", out_idx);
                end else begin
                    chk("out_idx", int'(out_idx), exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        reset     = 1'b0;
        match     = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        hist.delete();
        exp_cnt = 0;
        exp_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_ev_count", int'(ev_count), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        reset = 1'b1;
    endtask

    // One clock: apply inputs, advance the reference model, then check the registered state.
    // Model: hist holds match per cycle since reset; a 1->0 step at cycle t ends a run
    // whose last matching char is stream index t-2 (match trails the char by one cycle).
    task automatic cycle(input bit m, input bit r, input bit c, input byte ch);
        int  t;
        int  idx;
        bit  evt;
        bit  pop;
        bit  drop;
        match     = m;
        out_ready = r;
        clr       = c;
        in_char   = ch;
        t    = hist.size();
        evt  = (t > 0) && hist[t-1] && !m;
        idx  = (t - 2) & ((1 << POS_W) - 1);
        pop  = r && (exp_q.size() > 0);
        drop = 1'b0;
        if (evt) begin
            if (exp_q.size() < DEPTH || pop) exp_q.push_back(idx);
            else drop = 1'b1;
        end
        if (evt)    exp_cnt = c ? 1 : ((exp_cnt < CMAX) ? exp_cnt + 1 : CMAX);
        else if (c) exp_cnt = 0;
        if (c)         exp_ovf = drop;
        else if (drop) exp_ovf = 1'b1;
        hist.push_back(m);
        @(posedge clk);
        #1;
        chk("ev_count", int'(ev_count), exp_cnt);
        chk("overflow", int'(overflow), int'(exp_ovf));
        chk("out_valid", int'(out_valid), int'(exp_q.size() > 0));
        if (!out_valid) chk("out_idx_empty", int'(out_idx), 0);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(1'b0, r, 1'b0, 8'h20);
    endtask

    initial begin
        string s;
        int    mprof[8];

        // Reset in the middle of a run discards it.
        do_reset();
        s = "1.1.1";
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, byte'(s[i]));
        cycle(1'b1, 1'b1, 1'b0, 8'h20);
        do_reset();
        idle(4, 1'b1);

        // "1.1.12x": match for chars 4 and 5 -> one entry at index 5.
        do_reset();
        s = "1.1.12x ";
        mprof = '{0, 0, 0, 0, 0, 1, 1, 0};
        for (int i = 0; i < 8; i++) cycle(mprof[i] != 0, 1'b0, 1'b0, byte'(s[i]));
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Nine events into an 8-deep FIFO with no reader, then drain.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'h31);
            cycle(1'b0, 1'b0, 1'b0, 8'h78);
        end
        idle(2, 1'b0);
        chk("overflow_after_9", int'(overflow), 1);
        idle(12, 1'b1);

        // Full FIFO, event coincides with a pop: nothing dropped.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'h31);
            cycle(1'b0, 1'b0, 1'b0, 8'h78);
        end
        cycle(1'b1, 1'b0, 1'b0, 8'h31);
        cycle(1'b0, 1'b1, 1'b0, 8'h78);
        idle(2, 1'b0);
        chk("overflow_pop_push", int'(overflow), 0);
        idle(12, 1'b1);

        // Position wrap: runs ending at index 15 and then at index 2.
        do_reset();
        idle(16, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h31);
        cycle(1'b0, 1'b0, 1'b0, 8'h78);
        cycle(1'b0, 1'b0, 1'b0, 8'h78);
        cycle(1'b1, 1'b0, 1'b0, 8'h31);
        cycle(1'b0, 1'b0, 1'b0, 8'h78);
        idle(4, 1'b1);

        // clr coinciding with an event, clr alone, then counter saturation.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'h31);
            cycle(1'b0, 1'b1, 1'b0, 8'h78);
        end
        cycle(1'b1, 1'b1, 1'b0, 8'h31);
        cycle(1'b0, 1'b1, 1'b1, 8'h78);
        chk("clr_with_event", int'(ev_count), 1);
        cycle(1'b0, 1'b1, 1'b1, 8'h78);
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'h31);
            cycle(1'b0, 1'b1, 1'b0, 8'h78);
        end
        chk("saturated", int'(ev_count), CMAX);

        // Random traffic: random runs, reader stalls and occasional clears.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 1) != 0,
                  (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 49) == 0,
                  byte'($urandom_range(32, 126)));
        end
        idle(20, 1'b1);
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
